bnn_uart_tx_fifo: RTL and testbench

Buffered UART transmitter that returns response bytes from the BNN controller to the host. Bytes are pushed through a valid/ready handshake into a small FIFO, then serialised as 8N1 frames on `tx` at a bit period set by an internal divider. A new frame starts only while the host signals it can receive. This block is the transmit counterpart to the controller's command receive path.

---
 rtl/bnn_uart_tx_fifo_if.sv | 19 +
 rtl/bnn_uart_tx_fifo.sv | 172 +++++++++++++++++
 tb/tb_bnn_uart_tx_fifo.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bnn_uart_tx_fifo_if.sv
// Byte handshake between the BNN controller and the UART transmit FIFO.
// The master offers bytes with data_valid and the slave accepts them when data_ready is high.
interface bnn_uart_tx_fifo_if;
   logic [7:0] data_in;
   logic       data_valid;
   logic       data_ready;

   modport master (
      output data_in,
      output data_valid,
      input  data_ready
   );

   modport slave (
      input  data_in,
      input  data_valid,
      output data_ready
   );
endinterface

// File: rtl/bnn_uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small byte FIFO drains into a serialiser.
// A frame is launched only while the host signals that it can receive.
module bnn_uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   bnn_uart_tx_fifo_if.slave             s_in,
   input  logic                          i_peer_rts,
   output logic                          o_tx,
   output logic                          o_busy,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int DIV_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t           r_state;
   logic [7:0]       r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic [DIV_W-1:0] r_div;
   logic [2:0]       r_bit_idx;
   logic [7:0]       r_shift;
   logic             r_tx;
   logic             r_busy;

   logic w_ready;
   logic w_push;
   logic w_div_done;
   logic w_pop;

   // Handshake, divider terminal count and frame-launch (pop) decision.
   always_comb begin
      w_ready    = (r_count < DEPTH_C) && !i_rst;
      w_push     = s_in.data_valid && w_ready;
      w_div_done = (r_div == DIV_LAST);
      w_pop      = 1'b0;
      if ((r_count != {CNT_W{1'b0}}) && i_peer_rts) begin
         if (r_state == S_IDLE) begin
            w_pop = 1'b1;
         end else if ((r_state == S_STOP) && w_div_done) begin
            w_pop = 1'b1;
         end else begin
            w_pop = 1'b0;
         end
      end else begin
         w_pop = 1'b0;
      end
   end

   // Byte storage; contents need no reset because the pointers define validity.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= s_in.data_in;
      end
   end

   // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= {PTR_W{1'b0}};
         r_rd_ptr <= {PTR_W{1'b0}};
         r_count  <= {CNT_W{1'b0}};
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   r_count <= r_count - {{(CNT_W-1){1'b0}}, 1'b1};
            default: r_count <= r_count;
         endcase
      end
   end

   // Frame serialiser FSM with registered tx/busy outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_tx      <= 1'b1;
         r_busy    <= 1'b0;
         r_div     <= {DIV_W{1'b0}};
         r_bit_idx <= 3'd0;
         r_shift   <= 8'h00;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_div <= {DIV_W{1'b0}};
               if (w_pop) begin
                  r_state <= S_START;
                  r_tx    <= 1'b0;
                  r_busy  <= 1'b1;
                  r_shift <= r_mem[r_rd_ptr];
               end else begin
                  r_tx   <= 1'b1;
                  r_busy <= 1'b0;
               end
            end
            S_START: begin
               if (w_div_done) begin
                  r_div     <= {DIV_W{1'b0}};
                  r_state   <= S_DATA;
                  r_bit_idx <= 3'd0;
                  r_tx      <= r_shift[0];
                  r_shift   <= {1'b0, r_shift[7:1]};
               end else begin
                  r_div <= r_div + {{(DIV_W-1){1'b0}}, 1'b1};
               end
            end
            S_DATA: begin
               if (w_div_done) begin
                  r_div <= {DIV_W{1'b0}};
                  if (r_bit_idx == 3'd7) begin
                     r_state <= S_STOP;
                     r_tx    <= 1'b1;
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                     r_tx      <= r_shift[0];
                     r_shift   <= {1'b0, r_shift[7:1]};
                  end
               end else begin
                  r_div <= r_div + {{(DIV_W-1){1'b0}}, 1'b1};
               end
            end
            S_STOP: begin
               if (w_div_done) begin
                  r_div <= {DIV_W{1'b0}};
                  // Chain straight into the next start bit when a byte is waiting.
                  if (w_pop) begin
                     r_state <= S_START;
                     r_tx    <= 1'b0;
                     r_shift <= r_mem[r_rd_ptr];
                  end else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_div <= r_div + {{(DIV_W-1){1'b0}}, 1'b1};
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
               r_div   <= {DIV_W{1'b0}};
            end
         endcase
      end
   end

   assign s_in.data_ready = w_ready;
   assign o_tx            = r_tx;
   assign o_busy          = r_busy;
   assign o_fifo_count    = r_count;

endmodule

// File: tb/tb_bnn_uart_tx_fifo.sv
// Directed bench for bnn_uart_tx_fifo with a frame-decoding monitor on tx.
module tb_bnn_uart_tx_fifo;
   localparam int CPB = 4;

   typedef struct packed {
      logic [7:0] data;
      logic [9:0] exp_frame;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       peer_rts;
   logic       tx;
   logic       busy;
   logic [2:0] fifo_count;

   bnn_uart_tx_fifo_if u_if ();

   bnn_uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) u_dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .s_in         (u_if),
      .i_peer_rts   (peer_rts),
      .o_tx         (tx),
      .o_busy       (busy),
      .o_fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   logic [9:0] rx_q [$];
   int         rx_t [$];

   // Monitor: decode frames from tx, sampling mid-bit on the falling clock edge.
   initial begin : monitor
      bit         act;
      int         cnt;
      int         t0;
      logic [9:0] word;
      act = 1'b0;
      cnt = 0;
      t0 = 0;
      word = 10'h000;
      forever begin
         @(negedge clk);
         if (rst) begin
            act = 1'b0;
         end else if (!act) begin
            if (tx == 1'b0) begin
               act = 1'b1;
               cnt = 0;
               t0 = cyc;
            end
         end else begin
            cnt++;
         end
         if (act && (cnt % CPB == CPB / 2)) begin
            word = {tx, word[9:1]};
            if (cnt == 9 * CPB + CPB / 2) begin
               rx_q.push_back(word);
               rx_t.push_back(t0);
               act = 1'b0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push_byte(input logic [7:0] d);
      u_if.data_in = d;
      u_if.data_valid = 1'b1;
      tick();
      u_if.data_valid = 1'b0;
   endtask

   task automatic wait_frames(input string name, input int n, input int budget);
      int k;
      k = 0;
      while (rx_q.size() < n && k < budget) begin
         tick();
         k++;
      end
      chk(name, rx_q.size(), n);
   endtask

   task automatic wait_idle(input string name);
      int k;
      k = 0;
      while (busy && k < 200) begin
         tick();
         k++;
      end
      chk(name, {31'd0, busy}, 32'd0);
   endtask

   vec_t tab [12];
   int   acc [12];

   initial begin
      int n;
      int idx;
      int t;
      logic was_ready;

      tab[0]  = '{8'h11, 10'h222};
      tab[1]  = '{8'h22, 10'h244};
      tab[2]  = '{8'h33, 10'h266};
      tab[3]  = '{8'h44, 10'h288};
      tab[4]  = '{8'h55, 10'h2AA};
      tab[5]  = '{8'h66, 10'h2CC};
      tab[6]  = '{8'h77, 10'h2EE};
      tab[7]  = '{8'h88, 10'h310};
      tab[8]  = '{8'h99, 10'h332};
      tab[9]  = '{8'hAA, 10'h354};
      tab[10] = '{8'hBB, 10'h376};
      tab[11] = '{8'hCC, 10'h398};

      rst = 1'b1;
      peer_rts = 1'b0;
      u_if.data_in = 8'h00;
      u_if.data_valid = 1'b0;
      repeat (3) tick();
      chk("reset tx", {31'd0, tx}, 32'd1);
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset count", {29'd0, fifo_count}, 32'd0);
      chk("reset ready", {31'd0, u_if.data_ready}, 32'd0);
      rst = 1'b0;
      tick();
      chk("ready after reset", {31'd0, u_if.data_ready}, 32'd1);

      // Single byte 0xA5
      rx_q.delete(); rx_t.delete();
      peer_rts = 1'b1;
      push_byte(8'hA5);
      chk("single tx before launch", {31'd0, tx}, 32'd1);
      chk("single count after push", {29'd0, fifo_count}, 32'd1);
      tick();
      chk("single tx start", {31'd0, tx}, 32'd0);
      chk("single busy start", {31'd0, busy}, 32'd1);
      chk("single count after pop", {29'd0, fifo_count}, 32'd0);
      n = 1;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (busy) n++;
         else break;
      end
      chk("single busy length", n, 40);
      wait_frames("single frame count", 1, 50);
      if (rx_q.size() > 0) chk("single frame bits", {22'd0, rx_q[0]}, {22'd0, 10'h34A});
      tick();
      chk("single idle tx", {31'd0, tx}, 32'd1);

      // Back-to-back 0x00, 0xFF
      rx_q.delete(); rx_t.delete();
      u_if.data_in = 8'h00; u_if.data_valid = 1'b1;
      tick();
      chk("b2b count 1st", {29'd0, fifo_count}, 32'd1);
      u_if.data_in = 8'hFF;
      tick();
      u_if.data_valid = 1'b0;
      chk("b2b count 2nd", {29'd0, fifo_count}, 32'd1);
      chk("b2b tx start", {31'd0, tx}, 32'd0);
      repeat (39) tick();
      chk("b2b count held", {29'd0, fifo_count}, 32'd1);
      tick();
      chk("b2b count drained", {29'd0, fifo_count}, 32'd0);
      chk("b2b busy chained", {31'd0, busy}, 32'd1);
      wait_frames("b2b frame count", 2, 100);
      if (rx_q.size() >= 2) begin
         chk("b2b frame0", {22'd0, rx_q[0]}, {22'd0, 10'h200});
         chk("b2b frame1", {22'd0, rx_q[1]}, {22'd0, 10'h3FE});
         chk("b2b start spacing", rx_t[1] - rx_t[0], 40);
      end
      wait_idle("b2b idle");

      // Flow control: accumulate with peer_rts low
      rx_q.delete(); rx_t.delete();
      peer_rts = 1'b0;
      for (int i = 0; i < 4; i++) push_byte(tab[i].data);
      chk("flow count full", {29'd0, fifo_count}, 32'd4);
      chk("flow ready full", {31'd0, u_if.data_ready}, 32'd0);
      push_byte(8'h55);
      chk("flow push ignored", {29'd0, fifo_count}, 32'd4);
      chk("flow tx idle", {31'd0, tx}, 32'd1);
      peer_rts = 1'b1;
      wait_frames("flow frame count", 4, 400);
      for (int i = 0; i < 4 && i < rx_q.size(); i++)
         chk($sformatf("flow frame%0d", i), {22'd0, rx_q[i]}, {22'd0, tab[i].exp_frame});
      repeat (60) tick();
      chk("flow no extra frame", rx_q.size(), 4);
      chk("flow count empty", {29'd0, fifo_count}, 32'd0);

      // RTS drop mid-frame
      rx_q.delete(); rx_t.delete();
      push_byte(8'h3C);
      push_byte(8'h7E);
      repeat (14) tick();
      chk("rts busy in data", {31'd0, busy}, 32'd1);
      peer_rts = 1'b0;
      wait_frames("rts first frame", 1, 100);
      repeat (20) tick();
      chk("rts byte waiting", {29'd0, fifo_count}, 32'd1);
      chk("rts held idle", {31'd0, busy}, 32'd0);
      chk("rts no second frame", rx_q.size(), 1);
      if (rx_q.size() > 0) chk("rts frame 3C", {22'd0, rx_q[0]}, {22'd0, 10'h278});
      peer_rts = 1'b1;
      wait_frames("rts second frame", 2, 100);
      if (rx_q.size() >= 2) chk("rts frame 7E", {22'd0, rx_q[1]}, {22'd0, 10'h2FC});
      wait_idle("rts idle");

      // Continuous push across pointer wrap, push/pop collision while full
      rx_q.delete(); rx_t.delete();
      idx = 0;
      t = 0;
      while (idx < 12 && t < 1000) begin
         u_if.data_in = tab[idx].data;
         u_if.data_valid = 1'b1;
         was_ready = u_if.data_ready;
         tick();
         if (was_ready) begin
            acc[idx] = t;
            idx++;
         end
         t++;
      end
      u_if.data_valid = 1'b0;
      chk("wrap all pushed", idx, 12);
      chk("wrap push4 time", acc[4], 4);
      chk("wrap push5 after pop edge", acc[5], 42);
      chk("wrap push6 time", acc[6], 82);
      wait_frames("wrap frame count", 12, 800);
      for (int i = 0; i < 12 && i < rx_q.size(); i++)
         chk($sformatf("wrap frame%0d", i), {22'd0, rx_q[i]}, {22'd0, tab[i].exp_frame});
      wait_idle("wrap idle");

      // Reset during bit 3 of 0xC3 with two bytes queued
      rx_q.delete(); rx_t.delete();
      push_byte(8'hC3);
      push_byte(8'h5A);
      push_byte(8'h69);
      chk("rst queued", {29'd0, fifo_count}, 32'd2);
      repeat (16) tick();
      chk("rst busy before", {31'd0, busy}, 32'd1);
      chk("rst bit3 level", {31'd0, tx}, 32'd0);
      rst = 1'b1;
      tick();
      chk("rst tx", {31'd0, tx}, 32'd1);
      chk("rst busy", {31'd0, busy}, 32'd0);
      chk("rst count", {29'd0, fifo_count}, 32'd0);
      chk("rst ready", {31'd0, u_if.data_ready}, 32'd0);
      rst = 1'b0;
      repeat (100) tick();
      chk("rst no frames", rx_q.size(), 0);
      chk("rst stays idle", {31'd0, busy}, 32'd0);
      chk("rst tx high", {31'd0, tx}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
